// File: rtl/fpu_add_round.sv
// Double-precision add back end: rounds the aligned sum in one of four IEEE modes,
// resolves overflow and packs the result. Three stages under one global advance.
module fpu_add_round (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        sign,
  input  logic [55:0] sum_2,
  input  logic [10:0] exponent_2,
  input  logic        shift_inexact,
  input  logic [1:0]  rmode,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out,
  output logic        inexact,
  output logic        overflow,
  output logic        underflow
);
  localparam logic [1:0] RNE = 2'b00, RTZ = 2'b01, RUP = 2'b10, RDN = 2'b11;

  logic [3:1]  vld_pipe_q, vld_pipe_d;
  logic        advance;

  logic        s1_sign_q, s1_sign_d, s1_x_q, s1_x_d, s1_inc_q, s1_inc_d;
  logic [52:0] s1_mant_q, s1_mant_d;
  logic [10:0] s1_exp_q, s1_exp_d;
  logic [1:0]  s1_rmode_q, s1_rmode_d;

  logic        s2_sign_q, s2_sign_d, s2_x_q, s2_x_d;
  logic [51:0] s2_frac_q, s2_frac_d;
  logic [11:0] s2_exp_q, s2_exp_d;
  logic [1:0]  s2_rmode_q, s2_rmode_d;

  logic [63:0] out_q, out_d;
  logic        inexact_q, inexact_d, overflow_q, overflow_d, underflow_q, underflow_d;

  logic        x_in, inc_in, ovf, to_inf;
  logic [53:0] r_sum;
  logic        sum_unused;

  assign sum_unused = sum_2[55];

  always_comb begin
    advance   = !vld_pipe_q[3] | out_ready;
    in_ready  = advance;
    out_valid = vld_pipe_q[3];

    x_in = sum_2[1] | sum_2[0] | shift_inexact;
    unique case (rmode)
      RNE:     inc_in = sum_2[1] & (sum_2[0] | shift_inexact | sum_2[2]);
      RTZ:     inc_in = 1'b0;
      RUP:     inc_in = !sign & x_in;
      default: inc_in = sign & x_in;
    endcase

    r_sum = {1'b0, s1_mant_q} + {53'b0, s1_inc_q};

    // Directed rounding modes saturate to max finite when rounding away from the infinity.
    ovf    = s2_exp_q >= 12'd2047;
    to_inf = (s2_rmode_q == RNE) | ((s2_rmode_q == RUP) & !s2_sign_q) |
             ((s2_rmode_q == RDN) & s2_sign_q);

    vld_pipe_d = vld_pipe_q;
    s1_sign_d = s1_sign_q; s1_x_d = s1_x_q; s1_inc_d = s1_inc_q;
    s1_mant_d = s1_mant_q; s1_exp_d = s1_exp_q; s1_rmode_d = s1_rmode_q;
    s2_sign_d = s2_sign_q; s2_x_d = s2_x_q; s2_frac_d = s2_frac_q;
    s2_exp_d = s2_exp_q; s2_rmode_d = s2_rmode_q;
    out_d = out_q; inexact_d = inexact_q; overflow_d = overflow_q; underflow_d = underflow_q;

    if (advance) begin
      vld_pipe_d = {vld_pipe_q[2:1], in_valid};
      if (in_valid) begin
        s1_sign_d  = sign;
        s1_mant_d  = sum_2[54:2];
        s1_exp_d   = exponent_2;
        s1_x_d     = x_in;
        s1_inc_d   = inc_in;
        s1_rmode_d = rmode;
      end
      if (vld_pipe_q[1]) begin
        s2_sign_d  = s1_sign_q;
        s2_x_d     = s1_x_q;
        s2_rmode_d = s1_rmode_q;
        s2_frac_d  = r_sum[51:0];
        // Carry out of the mantissa, or a denormal rounding up into the normal range.
        s2_exp_d   = {1'b0, s1_exp_q} +
                     {11'b0, r_sum[53] | (!s1_mant_q[52] & r_sum[52])};
      end
      if (vld_pipe_q[2]) begin
        if (ovf)
          out_d = to_inf ? {s2_sign_q, 11'h7FF, 52'h0} : {s2_sign_q, 63'h7FEF_FFFF_FFFF_FFFF};
        else
          out_d = {s2_sign_q, s2_exp_q[10:0], s2_frac_q};
        inexact_d   = s2_x_q | ovf;
        overflow_d  = ovf;
        underflow_d = s2_x_q & !ovf & (s2_exp_q[10:0] == 11'd0);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_pipe_q <= '0;
      s1_sign_q <= 1'b0; s1_x_q <= 1'b0; s1_inc_q <= 1'b0;
      s1_mant_q <= '0; s1_exp_q <= '0; s1_rmode_q <= '0;
      s2_sign_q <= 1'b0; s2_x_q <= 1'b0; s2_frac_q <= '0;
      s2_exp_q <= '0; s2_rmode_q <= '0;
      out_q <= '0; inexact_q <= 1'b0; overflow_q <= 1'b0; underflow_q <= 1'b0;
    end else begin
      vld_pipe_q <= vld_pipe_d;
      s1_sign_q <= s1_sign_d; s1_x_q <= s1_x_d; s1_inc_q <= s1_inc_d;
      s1_mant_q <= s1_mant_d; s1_exp_q <= s1_exp_d; s1_rmode_q <= s1_rmode_d;
      s2_sign_q <= s2_sign_d; s2_x_q <= s2_x_d; s2_frac_q <= s2_frac_d;
      s2_exp_q <= s2_exp_d; s2_rmode_q <= s2_rmode_d;
      out_q <= out_d; inexact_q <= inexact_d; overflow_q <= overflow_d; underflow_q <= underflow_d;
    end
  end

  assign out       = out_q;
  assign inexact   = inexact_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;
endmodule
